im_fetch_arbiter: RTL
=====================

IM_FETCH_ARBITER -- requirements
Module: im_fetch_arbiter

Interface
REQ-001 The block SHALL have parameter bit_size, default 32, meaning the instruction word width.
REQ-002 The block SHALL have parameter mem_size, default 16, meaning the instruction address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req0, input, 1 bit: requester 0 (CPU fetch) read request, level.
REQ-006 The block SHALL have port addr0, input, mem_size bits: requester 0 address, stable while req0=1.
REQ-007 The block SHALL have port ack0, output, 1 bit: one-cycle pulse, rdata valid for requester 0.
REQ-008 The block SHALL have port req1, input, 1 bit: requester 1 (loader/debug) read request, level.
REQ-009 The block SHALL have port addr1, input, mem_size bits: requester 1 address, stable while req1=1.
REQ-010 The block SHALL have port ack1, output, 1 bit: one-cycle pulse, rdata valid for requester 1.
REQ-011 The block SHALL have port rdata, output, bit_size bits: registered read data shared by both requesters.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port gnt_id, output, 1 bit: index of the currently or last granted requester.
REQ-014 The block SHALL have port IM_Address, output, mem_size bits: address to instruction memory.
REQ-015 The block SHALL have port IM_en_Read, output, 1 bit: read enable to instruction memory.
REQ-016 The block SHALL have port Instruction, input, bit_size bits: data from instruction memory.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, HOLD, CAPT and ACK.
REQ-018 IDLE SHALL go to ISSUE when req0|req1 and otherwise stay IDLE; the winner is latched into gnt_id and its address into an internal addr register.
REQ-019 Arbitration SHALL be round-robin: on conflict, the requester not granted last wins; after reset, requester 0 has priority.
REQ-020 ISSUE SHALL drive IM_en_Read=1 and IM_Address=latched addr, then go to HOLD unconditionally.
REQ-021 HOLD SHALL drive IM_en_Read=0 and hold IM_Address, then go to CAPT; the memory latches the address at the end of HOLD.
REQ-022 CAPT SHALL hold IM_Address; on its exit edge rdata <= Instruction and the granted ack is set; the next state is ACK.
REQ-023 ACK SHALL assert exactly one of ack0/ack1 for one cycle (registered), with rdata valid in that cycle.
REQ-024 During arbitration in ACK, the acked requester's req SHALL be masked; if the other requester's req=1 it SHALL be granted and the next state is ISSUE, otherwise IDLE.
REQ-025 IM_en_Read SHALL be high only in ISSUE, for exactly one cycle per transaction.
REQ-026 Latency SHALL be: grant edge in IDLE -> ack 4 cycles later; back-to-back alternating transactions repeat every 4 cycles.
REQ-027 rdata SHALL hold its value until the next CAPT exit; outside ACK it is stale but stable.
REQ-028 If req drops mid-transaction, the transaction SHALL complete and the ack SHALL still pulse; there is no abort.
REQ-029 Requests and addresses SHALL be sampled only at the grant edge; address changes after the grant SHALL be ignored.
REQ-030 IM_Address SHALL not change between ISSUE and the end of CAPT.

Reset
REQ-031 When rst=0 at a clock edge, the block SHALL enter IDLE with IM_en_Read=0, IM_Address=0, ack0=ack1=0, rdata=0, busy=0, gnt_id=0, and last-grant pointing to requester 1 so that requester 0 wins first.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no ack; after release the FSM starts from IDLE.

Verification
REQ-033 Single read: IM[0x0010]=0xDEADBEEF, req0=1 with addr0=0x0010 at cycle 0 -> IM_en_Read=1 in cycle 1 only; ack0=1 and rdata=0xDEADBEEF in cycle 4; busy high in cycles 1-4.
REQ-034 Conflict: req0=req1=1 from reset, addr0=0x1, addr1=0x2 -> requester 0 is served first (ack0 in cycle 4), then requester 1 (ack1 in cycle 8, rdata=IM[0x2]); no idle cycle in between.
REQ-035 Fairness: req0 and req1 held high continuously -> acks alternate 0,1,0,1 every 4 cycles, with gnt_id toggling.
REQ-036 Address change: addr0 changes from 0x5 to 0x9 one cycle after the grant -> IM_Address stays 0x5 and rdata=IM[0x5].
REQ-037 Reset mid-op: rst=0 during HOLD -> next cycle is IDLE, IM_en_Read=0, no ack; a new req0 after reset completes normally in 4 cycles.
REQ-038 Request drop: req1 deasserted during HOLD -> ack1 still pulses in ACK, followed by IDLE if req0=0.

Source files
------------

// File: rtl/im_fetch_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port instruction memory.
// Each read is ISSUE/HOLD/CAPT/ACK, so grant-to-ack is four cycles.
module im_fetch_arbiter #(
    parameter int bit_size = 32,
    parameter int mem_size = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [mem_size-1:0] addr0,
    output logic                ack0,
    input  logic                req1,
    input  logic [mem_size-1:0] addr1,
    output logic                ack1,
    output logic [bit_size-1:0] rdata,
    output logic                busy,
    output logic                gnt_id,
    output logic [mem_size-1:0] IM_Address,
    output logic                IM_en_Read,
    input  logic [bit_size-1:0] Instruction
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        HOLD  = 3'd2,
        CAPT  = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_grant;
    logic                w_winner;
    logic                r_gnt;
    logic                r_last;
    logic [mem_size-1:0] r_addr;
    logic [bit_size-1:0] r_rdata;
    logic                r_ack0;
    logic                r_ack1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In ACK the just-served requester is masked, so only the other one can chain in.
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_winner = r_gnt;
        unique case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant  = 1'b1;
                    w_winner = (req0 && req1) ? ~r_last : req1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: w_next = HOLD;
            HOLD:  w_next = CAPT;
            CAPT:  w_next = ACK;
            ACK: begin
                if (r_gnt ? req0 : req1) begin
                    w_grant  = 1'b1;
                    w_winner = ~r_gnt;
                    w_next   = ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_rdata <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_grant) begin
                r_gnt  <= w_winner;
                r_last <= w_winner;
                r_addr <= w_winner ? addr1 : addr0;
            end
            // Memory output is valid in CAPT; capture it and raise the ack together.
            if (r_state == CAPT) begin
                r_rdata <= Instruction;
                r_ack0  <= ~r_gnt;
                r_ack1  <= r_gnt;
            end
        end
    end

    always_comb begin
        IM_en_Read = 1'b0;
        busy       = 1'b1;
        if (r_state == ISSUE) begin
            IM_en_Read = 1'b1;
        end
        if (r_state == IDLE) begin
            busy = 1'b0;
        end
    end

    assign IM_Address = r_addr;
    assign rdata      = r_rdata;
    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign gnt_id     = r_gnt;

endmodule
